// File: rtl/multicycle_function_unit_if.sv
// rtl/multicycle_function_unit_if.sv - operand/result bundle between register file, control and execute unit
interface multicycle_function_unit_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       FS;
  logic [2:0]       DA_in;
  logic [WIDTH-1:0] F;
  logic [2:0]       DA_out;
  logic             W;
  logic             done;
  logic             busy;
  logic             V;
  logic             C;
  logic             N;
  logic             Z;

  modport master (
    output start, A, B, FS, DA_in,
    input  F, DA_out, W, done, busy, V, C, N, Z
  );

  modport slave (
    input  start, A, B, FS, DA_in,
    output F, DA_out, W, done, busy, V, C, N, Z
  );
endinterface

// File: rtl/multicycle_function_unit.sv
// rtl/multicycle_function_unit.sv - execute stage: single-cycle ALU, iterative shifts and shift-add multiply
module multicycle_function_unit #(
  parameter int WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_function_unit_if.slave bus
);

  localparam logic [3:0] FS_MOVA = 4'd0;
  localparam logic [3:0] FS_INC  = 4'd1;
  localparam logic [3:0] FS_ADD  = 4'd2;
  localparam logic [3:0] FS_SUB  = 4'd3;
  localparam logic [3:0] FS_DEC  = 4'd4;
  localparam logic [3:0] FS_AND  = 4'd5;
  localparam logic [3:0] FS_OR   = 4'd6;
  localparam logic [3:0] FS_XOR  = 4'd7;
  localparam logic [3:0] FS_NOT  = 4'd8;
  localparam logic [3:0] FS_MOVB = 4'd9;
  localparam logic [3:0] FS_SHR  = 4'd10;
  localparam logic [3:0] FS_SHL  = 4'd11;
  localparam logic [3:0] FS_MUL  = 4'd12;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state, state_next;
  logic   accept, finish;

  logic [WIDTH-1:0] a_q, b_q, hi_q;
  logic [3:0]       fs_q;
  logic [2:0]       da_q;
  logic [4:0]       count_q;
  logic             shift_c_q;
  logic [4:0]       load_count;

  logic [WIDTH-1:0] f_q;
  logic [2:0]       da_out_q;
  logic             v_q, c_q, n_q, z_q, done_q;

  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   arith_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] res_f;
  logic             res_c, res_v;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (count_q == 5'd0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_count = 5'd0;
    case (bus.FS)
      FS_SHR, FS_SHL: load_count = {1'b0, bus.B[3:0]};
      FS_MUL:         load_count = 5'd16;
      default:        load_count = 5'd0;
    endcase
  end

  // INC/ADD/SUB/DEC share one adder; SUB is A + ~B + 1 so carry=1 means no borrow
  always_comb begin
    add_y   = '0;
    add_cin = 1'b0;
    case (fs_q)
      FS_INC: add_cin = 1'b1;
      FS_ADD: add_y   = b_q;
      FS_SUB: begin
        add_y   = ~b_q;
        add_cin = 1'b1;
      end
      FS_DEC: add_y   = '1;
      default: begin
        add_y   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  assign arith_sum = {1'b0, a_q} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

  // Multiply keeps the partial product as {hi_q, b_q}; the multiplier drains out of b_q's low end
  assign mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    res_f = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (fs_q)
      FS_MOVA: res_f = a_q;
      FS_INC, FS_ADD, FS_SUB, FS_DEC: begin
        res_f = arith_sum[WIDTH-1:0];
        res_c = arith_sum[WIDTH];
        res_v = (a_q[WIDTH-1] == add_y[WIDTH-1]) && (arith_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      FS_AND:  res_f = a_q & b_q;
      FS_OR:   res_f = a_q | b_q;
      FS_XOR:  res_f = a_q ^ b_q;
      FS_NOT:  res_f = ~a_q;
      FS_MOVB: res_f = b_q;
      FS_SHR, FS_SHL: begin
        res_f = a_q;
        res_c = shift_c_q;
      end
      FS_MUL: begin
        res_f = b_q;
        res_c = |hi_q;
      end
      default: res_f = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      fs_q      <= '0;
      da_q      <= '0;
      count_q   <= '0;
      shift_c_q <= 1'b0;
      f_q       <= '0;
      da_out_q  <= '0;
      v_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        a_q       <= bus.A;
        b_q       <= bus.B;
        fs_q      <= bus.FS;
        da_q      <= bus.DA_in;
        hi_q      <= '0;
        shift_c_q <= 1'b0;
        count_q   <= load_count;
      end else if (state == EXEC && count_q != 5'd0) begin
        count_q <= count_q - 5'd1;
        case (fs_q)
          FS_SHR: begin
            a_q       <= a_q >> 1;
            shift_c_q <= a_q[0];
          end
          FS_SHL: begin
            a_q       <= a_q << 1;
            shift_c_q <= a_q[WIDTH-1];
          end
          FS_MUL: begin
            hi_q <= mul_sum[WIDTH:1];
            b_q  <= {mul_sum[0], b_q[WIDTH-1:1]};
          end
          default: begin
            a_q <= a_q;
          end
        endcase
      end
      if (finish) begin
        f_q      <= res_f;
        da_out_q <= da_q;
        v_q      <= res_v;
        c_q      <= res_c;
        n_q      <= res_f[WIDTH-1];
        z_q      <= (res_f == '0);
      end
    end
  end

  assign bus.F      = f_q;
  assign bus.DA_out = da_out_q;
  assign bus.W      = done_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state == EXEC);
  assign bus.V      = v_q;
  assign bus.C      = c_q;
  assign bus.N      = n_q;
  assign bus.Z      = z_q;

endmodule

// File: tb/tb_multicycle_function_unit.sv
// tb/tb_multicycle_function_unit.sv - directed and randomized bench with an arithmetic reference model
module tb_multicycle_function_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multicycle_function_unit_if #(.WIDTH(16)) bus ();

  multicycle_function_unit #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] f;
    logic        v, c, n, z;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int          sa, sb, sr, ua, ub;
    int unsigned n;
    logic [31:0] p;
    e.f = '0; e.v = 0; e.c = 0; e.lat = 1;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b; sr = 0; n = b[3:0];
    case (fs)
      4'd0:  e.f = a;
      4'd1:  begin e.f = a + 16'd1; e.c = (ua + 1 > 65535); sr = sa + 1; end
      4'd2:  begin e.f = a + b;     e.c = (ua + ub > 65535); sr = sa + sb; end
      4'd3:  begin e.f = a - b;     e.c = (ua >= ub);        sr = sa - sb; end
      4'd4:  begin e.f = a - 16'd1; e.c = (ua != 0);         sr = sa - 1; end
      4'd5:  e.f = a & b;
      4'd6:  e.f = a | b;
      4'd7:  e.f = a ^ b;
      4'd8:  e.f = ~a;
      4'd9:  e.f = b;
      4'd10: begin e.f = a >> n; e.c = (n != 0) ? a[n-1] : 1'b0;  e.lat = n + 1; end
      4'd11: begin e.f = a << n; e.c = (n != 0) ? a[16-n] : 1'b0; e.lat = n + 1; end
      4'd12: begin
        p = ua * ub;
        e.f = p[15:0]; e.c = (p[31:16] != 16'd0); e.lat = 17;
      end
      default: e.f = '0;
    endcase
    if (fs >= 4'd1 && fs <= 4'd4) e.v = (sr > 32767) || (sr < -32768);
    e.n = e.f[15];
    e.z = (e.f == 16'd0);
    return e;
  endfunction

  // Caller is at a negedge; returns at the negedge of the done cycle so a follow-up op is back-to-back
  task automatic do_op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] da, input bit inject);
    exp_t e;
    int   lat, busy_cnt;
    bit   got;
    e = model(fs, a, b);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.FS = fs; bus.DA_in = da;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    bus.A = 16'($urandom); bus.B = 16'($urandom); bus.FS = 4'($urandom); bus.DA_in = 3'($urandom);
    check("busy_after_start", bus.busy, 1);
    check("done_low_after_start", bus.done, 0);
    lat = 0; busy_cnt = 1; got = 0;
    while (!got && lat < 40) begin
      if (inject && lat == 3) begin
        bus.start = 1'b1; bus.FS = 4'd2; bus.A = 16'h1111; bus.B = 16'h2222; bus.DA_in = ~da;
      end
      @(posedge clock);
      lat++;
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.done) got = 1;
      else if (bus.busy) busy_cnt++;
    end
    check("latency", lat, e.lat);
    check("busy_cycles", busy_cnt, e.lat);
    check("w_eq_done", bus.W, 1);
    check("busy_in_done", bus.busy, 0);
    check("result_f", bus.F, e.f);
    check("flag_v", bus.V, e.v);
    check("flag_c", bus.C, e.c);
    check("flag_n", bus.N, e.n);
    check("flag_z", bus.Z, e.z);
    check("da_out", bus.DA_out, da);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_f"}, bus.F, 0);
    check({tag, "_da"}, bus.DA_out, 0);
    check({tag, "_flags"}, {bus.V, bus.C, bus.N, bus.Z}, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done_w"}, {bus.done, bus.W}, 0);
  endtask

  initial begin
    logic [15:0] held_f;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.FS = '0; bus.DA_in = '0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    do_op(4'd2,  16'h7FFF, 16'h0001, 3'd3, 0);
    do_op(4'd3,  16'h0005, 16'h0005, 3'd1, 0);
    do_op(4'd3,  16'h0000, 16'h0001, 3'd2, 0);
    do_op(4'd11, 16'h1001, 16'h0004, 3'd4, 0);
    do_op(4'd10, 16'h8000, 16'h0000, 3'd5, 0);
    do_op(4'd12, 16'h0003, 16'h0007, 3'd6, 0);
    do_op(4'd12, 16'h0100, 16'h0100, 3'd7, 0);
    do_op(4'd12, 16'hBEEF, 16'h1234, 3'd2, 1);
    do_op(4'd1,  16'hFFFF, 16'h0000, 3'd0, 0);
    do_op(4'd4,  16'h8000, 16'h0000, 3'd1, 0);
    do_op(4'd14, 16'h1234, 16'h5678, 3'd3, 0);

    held_f = bus.F;
    do_op(4'd0, 16'h4321, 16'h0000, 3'd6, 0);
    held_f = 16'h4321;
    repeat (3) begin
      @(negedge clock);
      check("hold_f", bus.F, held_f);
      check("hold_done", bus.done, 0);
    end

    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_op(4'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), bit'($urandom_range(0, 1)));
    end

    do_op(4'd0, 16'h1234, 16'h0000, 3'd5, 0);
    @(negedge clock);
    bus.start = 1'b1; bus.FS = 4'd12; bus.A = 16'h00FF; bus.B = 16'h00FF; bus.DA_in = 3'd7;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) begin
      @(negedge clock);
      check_all_zero("in_reset");
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clock);
      check("no_done_after_abort", bus.done, 0);
    end
    do_op(4'd9, 16'h5555, 16'hABCD, 3'd4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_function_unit.md
Name: multicycle_function_unit

Overview:
- Execute stage directly downstream of the 8x16 register file.
- Consumes the register file's A/B read buses and produces the write-back result on its D input, with write enable on W and destination on DA.
- Single-cycle ALU ops plus iterative shift (1 bit/cycle) and shift-add multiply, under a start/busy/done handshake.
- Also provides V/C/N/Z status flags for the control unit.

Parameters:
- WIDTH, 16, datapath width. Only 16 is verified. Shift amount is always B[3:0].

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  request; sampled only when busy=0
- A  in  16  operand A, from register file A bus
- B  in  16  operand B, from register file B bus
- FS  in  4  function select
- DA_in  in  3  destination register address for this op
- F  out  16  result; drives register file D
- DA_out  out  3  latched destination; drives register file DA
- W  out  1  write enable to register file; equals done
- done  out  1  one-cycle completion pulse
- busy  out  1  high while an op is in flight
- V, C, N, Z  out  1 each  status flags of last completed op

Behaviour:
- Reset (reset=0, async): state=IDLE; F, DA_out, flags, busy, done, W all 0. Takes effect immediately. An op in progress is aborted with no done/W pulse and no F update.
- FSM states: IDLE, EXEC.
- IDLE: on a clock edge with start=1, latch A, B, FS and DA_in.
  - Load count: B[3:0] for SHR/SHL, 16 for MUL, 0 otherwise.
  - Go to EXEC; busy=1.
  - start while busy=1 is ignored; no queueing.
- EXEC, each edge:
  - If count=0: load F, flags and DA_out; assert done=W=1 for exactly one cycle; busy=0; go to IDLE.
  - Otherwise: perform one iteration (1-bit shift, or one multiply add/shift step) and decrement count.
- Latency, with start sampled at edge 0: done is high after edge 1 for non-shift ops, after edge n+1 for shifts by n (n=0 gives edge 1), and after edge 17 for MUL.
- Back-to-back: busy=0 during the done cycle, so a start sampled at the next edge is accepted.
- Operand buses may change after the start edge without affecting the result.
- F, flags and DA_out hold their values between completions.
- FS encoding (arithmetic is modulo 2^16):
  - 0 MOVA: F=A
  - 1 INC: A+1
  - 2 ADD: A+B
  - 3 SUB: A+~B+1
  - 4 DEC: A+0xFFFF
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 NOT: ~A
  - 9 MOVB: F=B
  - 10 SHR: logical right by B[3:0]
  - 11 SHL: left by B[3:0], zero fill
  - 12 MUL: low 16 bits of unsigned A*B
  - 13-15 reserved: F=0, single-cycle
- Flags, updated only at completion:
  - Z: F==0.
  - N: F[15].
  - C, arithmetic ops 1-4: carry out of bit 15. SUB with C=1 means no borrow.
  - V, arithmetic ops 1-4: signed overflow.
  - Logic ops, moves and reserved ops: C=V=0.
  - Shifts: C = last bit shifted out (0 if n=0); V=0.
  - MUL: C=1 iff the upper 16 product bits are nonzero; V=0.

Test Plan:
- ADD A=0x7FFF, B=0x0001, DA_in=3 → done and W high after edge 1 only; F=0x8000, V=1, N=1, C=0, Z=0, DA_out=3.
- SUB A=5, B=5 → F=0, Z=1, C=1, V=0, N=0. Then SUB A=0, B=1 → F=0xFFFF, C=0, N=1.
- SHL A=0x1001, B=4 → busy for 5 cycles; done after edge 5; F=0x0010, C=1. Then SHR A=0x8000, B=0 → done after edge 1, F=0x8000, C=0.
- MUL A=3, B=7 → done after edge 17, F=21, C=0. Then MUL A=0x0100, B=0x0100 → F=0, Z=1, C=1.
- Start MUL, then pulse start with ADD and different operands during busy → ADD ignored; one done only, with the MUL result. Start a new op in the cycle after done → accepted.
- Assert reset=0 mid-MUL (edge 8) → F=0, all flags 0, busy=0, no done/W. After release, MOVB B=0xABCD → F=0xABCD after edge 1.
